// File: rtl/spi_flash_rd_if.sv
// Bundles the flash-read controller's three handshakes: the request side,
// the SPI byte engine side and the read-data stream to the consumer.
// Ports:
//   request : req_i, req_addr_i, req_len_i -> busy_o, done_o
//   engine  : cs_n_o, tx_byte_o, tx_byte_valid_o <- ready_i, rx_byte_i, rx_byte_valid_i
//   stream  : rd_data_o, rd_valid_o <- rd_ready_i
// master is the controller's view; slave is the view of everything around it.
interface spi_flash_rd_if #(
  parameter int LEN_W = 16
);
  // request side
  logic             req_i;
  logic [23:0]      req_addr_i;
  logic [LEN_W-1:0] req_len_i;
  logic             busy_o;
  logic             done_o;

  // SPI byte engine side
  logic             cs_n_o;
  logic [7:0]       tx_byte_o;
  logic             tx_byte_valid_o;
  logic             ready_i;
  logic [7:0]       rx_byte_i;
  logic             rx_byte_valid_i;

  // read data stream
  logic [7:0]       rd_data_o;
  logic             rd_valid_o;
  logic             rd_ready_i;

  modport master (
    input  req_i, req_addr_i, req_len_i,
    output busy_o, done_o,
    output cs_n_o, tx_byte_o, tx_byte_valid_o,
    input  ready_i, rx_byte_i, rx_byte_valid_i,
    output rd_data_o, rd_valid_o,
    input  rd_ready_i
  );

  modport slave (
    output req_i, req_addr_i, req_len_i,
    input  busy_o, done_o,
    input  cs_n_o, tx_byte_o, tx_byte_valid_o,
    output ready_i, rx_byte_i, rx_byte_valid_i,
    input  rd_data_o, rd_valid_o,
    output rd_ready_i
  );
endinterface

// File: rtl/spi_flash_rd.sv
// SPI flash read sequencer: sends CMD_RD + 24-bit address, then clocks dummy bytes to read req_len bytes.
// Latency: request accepted on the clock edge it is seen in IDLE; done_o one cycle after the last data byte returns.
// Backpressure: one byte in flight at a time; no new dummy byte is issued while rd_valid_o is held.
// Ports: clk, rst (synchronous, active-high); bus (spi_flash_rd_if.master) carries the request,
//        byte-engine and read-data handshakes.
module spi_flash_rd #(
  parameter logic [7:0] CMD_RD = 8'h03,
  parameter int         LEN_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  spi_flash_rd_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [23:0]      addr;
  logic [LEN_W-1:0] remain;
  logic [1:0]       addr_idx;
  logic             pending;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [7:0]       tx_byte;

  logic             in_xfer;
  logic             accept;
  logic             issue;
  logic             rx_take;
  logic             data_rx;
  logic             last_data;

  // CS is owned here for the whole CMD..DATA window, regardless of the
  // engine's own per-byte framing.
  assign in_xfer   = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);

  // A held read byte blocks acceptance so the old stream never mixes
  // with a new one.
  assign accept    = (state == S_IDLE) && bus.req_i && !rd_valid;

  // Stray engine strobes (nothing outstanding) are ignored.
  assign rx_take   = in_xfer && pending && bus.rx_byte_valid_i;
  assign data_rx   = (state == S_DATA) && rx_take;
  assign last_data = (remain == LEN_ONE);

  // In DATA, the next dummy byte waits for the consumer to drain the
  // previous one; that is the only point where SPI traffic stalls.
  assign issue     = in_xfer && bus.ready_i && !pending &&
                     !((state == S_DATA) && rd_valid);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (bus.req_len_i == LEN_ZERO) ? S_DONE : S_CMD;
        end
      end
      S_CMD: begin
        if (rx_take) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_take && (addr_idx == 2'd2)) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_take && last_data) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outgoing byte: opcode, address MSB first, then zero dummies.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_CMD: begin
        tx_byte = CMD_RD;
      end
      S_ADDR: begin
        case (addr_idx)
          2'd0:    tx_byte = addr[23:16];
          2'd1:    tx_byte = addr[15:8];
          default: tx_byte = addr[7:0];
        endcase
      end
      default: begin
        tx_byte = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= 24'h000000;
      remain   <= LEN_ZERO;
      addr_idx <= 2'd0;
      pending  <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        addr     <= bus.req_addr_i;
        remain   <= bus.req_len_i;
        addr_idx <= 2'd0;
      end

      // issue and rx_take are mutually exclusive: issue needs pending=0,
      // rx_take needs pending=1.
      if (issue) begin
        pending <= 1'b1;
      end else if (rx_take) begin
        pending <= 1'b0;
      end

      if ((state == S_ADDR) && rx_take) begin
        addr_idx <= addr_idx + 2'd1;
      end

      if (data_rx) begin
        remain  <= remain - LEN_ONE;
        rd_data <= bus.rx_byte_i;
      end

      // A data byte can only arrive while rd_valid is low (issue is gated
      // on it), so load and handshake-clear never collide.
      if (data_rx) begin
        rd_valid <= 1'b1;
      end else if (rd_valid && bus.rd_ready_i) begin
        rd_valid <= 1'b0;
      end
    end
  end

  assign bus.busy_o          = (state != S_IDLE);
  assign bus.done_o          = (state == S_DONE);
  assign bus.cs_n_o          = !in_xfer;
  assign bus.tx_byte_o       = tx_byte;
  assign bus.tx_byte_valid_o = issue;
  assign bus.rd_data_o       = rd_data;
  assign bus.rd_valid_o      = rd_valid;

endmodule

// File: tb/tb_spi_flash_rd.sv
module tb_spi_flash_rd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_flash_rd_if #(.LEN_W(16)) bus ();

  spi_flash_rd #(.CMD_RD(8'h03), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    logic [31:0] dat;      // flash data bytes, first byte in [31:24]
    logic [63:0] exp_tx;   // expected tx bytes, first byte in [63:56]
    int          exp_ntx;
    int          mode;     // consumer ready mode
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // logs and reference queues
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rd_q[$];
  int done_cnt   = 0;
  int viol       = 0;
  int cs_low_cnt = 0;
  int min_gap    = 1000;
  int rd_mode    = 0;   // 0 always ready, 1 never ready, 2 random
  bit spur       = 1'b0;

  // flash / engine model state
  bit eng_pend  = 1'b0;
  int eng_lat   = 0;
  bit eng_data  = 1'b0;
  int txn_idx   = 0;
  int cs_hi_run = 0;
  bit cs_seen   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Engine, consumer and monitor: sample on negedge, drive #1 after posedge.
  initial begin : env
    logic s_txv, s_cs, s_rdv, s_rdr, s_done, s_rst;
    logic [7:0] s_tx, s_rdd;
    bus.ready_i         = 1'b1;
    bus.rx_byte_valid_i = 1'b0;
    bus.rx_byte_i       = 8'h00;
    bus.rd_ready_i      = 1'b1;
    forever begin
      @(negedge clk);
      s_txv  = bus.tx_byte_valid_o;
      s_tx   = bus.tx_byte_o;
      s_cs   = bus.cs_n_o;
      s_rdv  = bus.rd_valid_o;
      s_rdd  = bus.rd_data_o;
      s_rdr  = bus.rd_ready_i;
      s_done = bus.done_o;
      s_rst  = rst;
      if (!s_rst) begin
        if (s_txv) begin
          tx_q.push_back(s_tx);
          if (s_cs || eng_pend) viol++;
          if (s_rdv && txn_idx >= 4) viol++;
        end
        if (s_rdv && s_rdr) rd_q.push_back(s_rdd);
        if (s_done) done_cnt++;
        if (s_cs) begin
          cs_hi_run++;
        end else begin
          if (cs_seen && cs_hi_run > 0 && cs_hi_run < min_gap) min_gap = cs_hi_run;
          cs_hi_run = 0;
          cs_seen   = 1'b1;
          cs_low_cnt++;
        end
      end
      @(posedge clk);
      #1;
      if (s_rst) begin
        eng_pend            = 1'b0;
        eng_lat             = 0;
        txn_idx             = 0;
        bus.ready_i         = 1'b1;
        bus.rx_byte_valid_i = 1'b0;
      end else begin
        bus.rx_byte_valid_i = 1'b0;
        if (s_cs) txn_idx = 0;
        if (s_txv) begin
          eng_pend    = 1'b1;
          eng_lat     = $urandom_range(1, 3);
          eng_data    = (txn_idx >= 4);
          txn_idx++;
          bus.ready_i = 1'b0;
        end else if (eng_pend) begin
          eng_lat--;
          if (eng_lat == 0) begin
            eng_pend            = 1'b0;
            bus.ready_i         = 1'b1;
            bus.rx_byte_valid_i = 1'b1;
            if (eng_data && resp_q.size() > 0) bus.rx_byte_i = resp_q.pop_front();
            else bus.rx_byte_i = 8'($urandom);
          end
        end else if (spur) begin
          spur                = 1'b0;
          bus.rx_byte_valid_i = 1'b1;
          bus.rx_byte_i       = 8'h77;
        end
      end
      case (rd_mode)
        0:       bus.rd_ready_i = 1'b1;
        1:       bus.rd_ready_i = 1'b0;
        default: bus.rd_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_logs();
    tx_q.delete();
    rd_q.delete();
    resp_q.delete();
    exp_tx_q.delete();
    exp_rd_q.delete();
    done_cnt   = 0;
    viol       = 0;
    cs_low_cnt = 0;
    min_gap    = 1000;
  endtask

  // Reference: a read is opcode, 3 address bytes MSB first, len dummies;
  // zero length puts nothing on the bus.
  task automatic model_txn(input logic [23:0] a, input logic [15:0] l);
    if (l != 16'd0) begin
      exp_tx_q.push_back(8'h03);
      exp_tx_q.push_back(a[23:16]);
      exp_tx_q.push_back(a[15:8]);
      exp_tx_q.push_back(a[7:0]);
      for (int i = 0; i < int'(l); i++) exp_tx_q.push_back(8'h00);
    end
  endtask

  task automatic add_data(input logic [7:0] d);
    resp_q.push_back(d);
    exp_rd_q.push_back(d);
  endtask

  task automatic cmp_logs(input string tag);
    int bad;
    chk({tag, "_ntx"}, tx_q.size(), exp_tx_q.size());
    bad = 0;
    for (int i = 0; i < exp_tx_q.size(); i++)
      if (i >= tx_q.size() || tx_q[i] !== exp_tx_q[i]) bad++;
    chk({tag, "_txbytes_bad"}, bad, 0);
    chk({tag, "_nrd"}, rd_q.size(), exp_rd_q.size());
    bad = 0;
    for (int i = 0; i < exp_rd_q.size(); i++)
      if (i >= rd_q.size() || rd_q[i] !== exp_rd_q[i]) bad++;
    chk({tag, "_rdbytes_bad"}, bad, 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.busy_o && !bus.rd_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic wait_settle(input string tag, input int n_rd, input int n_done);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_q.size() >= n_rd && done_cnt >= n_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_settled"}, ok, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [23:0] a, input logic [15:0] l);
    wait_idle();
    @(posedge clk);
    #1;
    bus.req_i      = 1'b1;
    bus.req_addr_i = a;
    bus.req_len_i  = l;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
  endtask

  // k = sampling point (negedge count after req is driven) where done_o is first seen
  task automatic issue_req(input logic [23:0] a, input logic [15:0] l,
                           output int k, output logic b1, output logic b2);
    wait_idle();
    @(posedge clk);
    #1;
    bus.req_i      = 1'b1;
    bus.req_addr_i = a;
    bus.req_len_i  = l;
    k  = -1;
    b2 = 1'bx;
    @(negedge clk);
    b1 = bus.busy_o;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    for (int i = 2; i < 3000; i++) begin
      @(negedge clk);
      if (i == 2) b2 = bus.busy_o;
      if (bus.done_o) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin : main
    vec_t vt[5];
    int   k, bad, hi, rv;
    logic b1, b2;
    bit   ok;
    logic [23:0] ra;
    logic [15:0] rl;

    vt[0] = '{24'h012345, 16'd2, 32'hAABB0000, 64'h0301234500000000, 6, 0};
    vt[1] = '{24'hFFFFFF, 16'd1, 32'h5A000000, 64'h03FFFFFF00000000, 5, 0};
    vt[2] = '{24'h000000, 16'd0, 32'h00000000, 64'h0000000000000000, 0, 0};
    vt[3] = '{24'hA5C30F, 16'd3, 32'h11223300, 64'h03A5C30F00000000, 7, 2};
    vt[4] = '{24'h800001, 16'd4, 32'hDEADBEEF, 64'h0380000100000000, 8, 0};

    rst            = 1'b1;
    bus.req_i      = 1'b0;
    bus.req_addr_i = 24'h000000;
    bus.req_len_i  = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n",     bus.cs_n_o, 1);
    chk("rst_tx_valid", bus.tx_byte_valid_o, 0);
    chk("rst_tx_byte",  bus.tx_byte_o, 8'h00);
    chk("rst_busy",     bus.busy_o, 0);
    chk("rst_done",     bus.done_o, 0);
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_rd_data",  bus.rd_data_o, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // table-driven transactions
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      clear_logs();
      rd_mode = vt[v].mode;
      for (int j = 0; j < int'(vt[v].len); j++) resp_q.push_back(vt[v].dat[31-8*j -: 8]);
      issue_req(vt[v].addr, vt[v].len, k, b1, b2);
      chk("tbl_done_seen", k > 0, 1);
      chk("tbl_busy_before_accept", b1, 0);
      chk("tbl_busy_after_accept", b2, 1);
      if (vt[v].len == 16'd0) begin
        chk("tbl_zero_done_time", k, 2);
        chk("tbl_zero_cs_low_cycles", cs_low_cnt, 0);
      end
      wait_settle("tbl", int'(vt[v].len), 1);
      chk("tbl_ntx", tx_q.size(), vt[v].exp_ntx);
      bad = 0;
      for (int j = 0; j < vt[v].exp_ntx; j++)
        if (j >= tx_q.size() || tx_q[j] !== vt[v].exp_tx[63-8*j -: 8]) bad++;
      chk("tbl_txbytes_bad", bad, 0);
      chk("tbl_nrd", rd_q.size(), vt[v].len);
      bad = 0;
      for (int j = 0; j < int'(vt[v].len); j++)
        if (j >= rd_q.size() || rd_q[j] !== vt[v].dat[31-8*j -: 8]) bad++;
      chk("tbl_rdbytes_bad", bad, 0);
      chk("tbl_done_count", done_cnt, 1);
      chk("tbl_protocol", viol, 0);
      chk("tbl_busy_end", bus.busy_o, 0);
    end
    rd_mode = 0;

    // backpressure: consumer stalls 20 cycles on the first data byte
    wait_idle();
    clear_logs();
    model_txn(24'h00C0DE, 16'd3);
    add_data(8'h31); add_data(8'h32); add_data(8'h33);
    rd_mode = 1;
    pulse_req(24'h00C0DE, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.rd_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_first_byte", ok, 1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cs_n_o) hi++;
    end
    chk("bp_tx_stalled", tx_q.size(), 5);
    chk("bp_cs_held_low", hi, 0);
    chk("bp_rd_valid_held", bus.rd_valid_o, 1);
    chk("bp_rd_data_held", bus.rd_data_o, 8'h31);
    rd_mode = 0;
    wait_settle("bp", 3, 1);
    cmp_logs("bp");
    chk("bp_done_count", done_cnt, 1);
    chk("bp_protocol", viol, 0);

    // second request during busy is ignored
    wait_idle();
    clear_logs();
    model_txn(24'h111111, 16'd1);
    add_data(8'h4C);
    @(posedge clk);
    #1;
    bus.req_i      = 1'b1;
    bus.req_addr_i = 24'h111111;
    bus.req_len_i  = 16'd1;
    @(posedge clk);
    #1;
    bus.req_addr_i = 24'h999999;
    bus.req_len_i  = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    wait_settle("ign", 1, 1);
    cmp_logs("ign");
    chk("ign_done_count", done_cnt, 1);
    chk("ign_busy_end", bus.busy_o, 0);

    // spurious engine strobe in IDLE
    wait_idle();
    clear_logs();
    spur = 1'b1;
    rv   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rd_valid_o) rv++;
    end
    chk("spur_rd_valid", rv, 0);
    chk("spur_busy", bus.busy_o, 0);
    chk("spur_nrd", rd_q.size(), 0);

    // reset in the middle of DATA
    wait_idle();
    clear_logs();
    resp_q.push_back(8'hC1); resp_q.push_back(8'hC2);
    resp_q.push_back(8'hC3); resp_q.push_back(8'hC4);
    pulse_req(24'h0A0B0C, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_two_bytes", ok, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs_n", bus.cs_n_o, 1);
    chk("mid_rst_rd_valid", bus.rd_valid_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    repeat (10) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_nrd", rd_q.size(), 2);
    clear_logs();
    model_txn(24'h00ABCD, 16'd1);
    add_data(8'h5E);
    pulse_req(24'h00ABCD, 16'd1);
    wait_settle("post_rst", 1, 1);
    cmp_logs("post_rst");
    chk("post_rst_done_count", done_cnt, 1);

    // back-to-back: request held high so the second is taken at the first legal cycle
    wait_idle();
    clear_logs();
    model_txn(24'h123456, 16'd1);
    model_txn(24'h123456, 16'd1);
    add_data(8'h61); add_data(8'h62);
    @(posedge clk);
    #1;
    bus.req_i      = 1'b1;
    bus.req_addr_i = 24'h123456;
    bus.req_len_i  = 16'd1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_first_done", ok, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    wait_settle("b2b", 2, 2);
    cmp_logs("b2b");
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_cs_gap_ge2", min_gap >= 2, 1);
    chk("b2b_protocol", viol, 0);

    // randomized transactions against the reference model
    rd_mode = 2;
    for (int t = 0; t < 40; t++) begin
      wait_idle();
      clear_logs();
      ra = 24'($urandom);
      rl = 16'($urandom_range(0, 6));
      model_txn(ra, rl);
      for (int j = 0; j < int'(rl); j++) add_data(8'($urandom));
      pulse_req(ra, rl);
      wait_settle("rnd", int'(rl), 1);
      cmp_logs("rnd");
      chk("rnd_done_count", done_cnt, 1);
      chk("rnd_protocol", viol, 0);
      if (rl == 16'd0) chk("rnd_zero_cs_low_cycles", cs_low_cnt, 0);
    end
    rd_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
